// File: rtl/pipe_sched_if.sv
// pipe_sched_if: decode-side inputs and pipeline control outputs of the sequencing controller
interface pipe_sched_if;
  logic       id_valid;
  logic [1:0] id_ra;
  logic [1:0] id_rb;
  logic [1:0] id_reads;
  logic       id_wr;
  logic [1:0] id_rd;
  logic       id_load;
  logic       id_mem;
  logic       ex_taken;
  logic       int_req;
  logic       pc_en;
  logic [1:0] pc_sel;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       int_push;
  logic       int_ack;
  modport master (
    output id_valid, id_ra, id_rb, id_reads, id_wr, id_rd, id_load, id_mem, ex_taken, int_req,
    input  pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b, int_push, int_ack
  );
  modport slave (
    input  id_valid, id_ra, id_rb, id_reads, id_wr, id_rd, id_load, id_mem, ex_taken, int_req,
    output pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b, int_push, int_ack
  );
endinterface

// File: rtl/pipe_sched.sv
// pipe_sched: hazard, forwarding and interrupt-entry sequencing for the IF/ID/EX/MEM pipeline
module pipe_sched (
  input  logic         clk,
  input  logic         rst,
  pipe_sched_if.slave  bus
);
  typedef struct packed {
    logic       v;
    logic       wr;
    logic [1:0] rd;
    logic       load;
    logic       mem;
  } shadow_t;
  typedef enum logic [1:0] {IDLE, DRAIN, PUSH, VECTOR} state_t;
  shadow_t ex_s, mem_s;
  state_t  state, nxt;
  logic ex_a, ex_b, mem_a, mem_b, load_use, struct_hz, drained;
  assign ex_a  = ex_s.v  & ex_s.wr  & (ex_s.rd  == bus.id_ra) & bus.id_reads[1] & bus.id_valid;
  assign ex_b  = ex_s.v  & ex_s.wr  & (ex_s.rd  == bus.id_rb) & bus.id_reads[0] & bus.id_valid;
  assign mem_a = mem_s.v & mem_s.wr & (mem_s.rd == bus.id_ra) & bus.id_reads[1] & bus.id_valid;
  assign mem_b = mem_s.v & mem_s.wr & (mem_s.rd == bus.id_rb) & bus.id_reads[0] & bus.id_valid;
  assign load_use  = (ex_a | ex_b) & ex_s.load;
  assign struct_hz = mem_s.v & mem_s.mem;
  assign drained   = ~bus.id_valid & ~ex_s.v & ~mem_s.v;
  always_comb begin
    bus.fwd_a = rst ? 2'b00 : (ex_a & ~ex_s.load) ? 2'b01 : mem_a ? 2'b10 : 2'b00;
    bus.fwd_b = rst ? 2'b00 : (ex_b & ~ex_s.load) ? 2'b01 : mem_b ? 2'b10 : 2'b00;
    nxt = state == IDLE  ? (bus.int_req ? DRAIN : IDLE) :
          state == DRAIN ? (drained ? PUSH : DRAIN) :
          state == PUSH  ? VECTOR : IDLE;
  end
  // Control outputs follow the stall/flush priority; a taken branch still redirects while draining
  always_comb begin
    bus.pc_en      = 1'b1;
    bus.pc_sel     = 2'b00;
    bus.ifid_en    = 1'b1;
    bus.ifid_flush = 1'b0;
    bus.idex_flush = 1'b0;
    bus.int_push   = 1'b0;
    bus.int_ack    = 1'b0;
    if (rst) begin
      bus.pc_en      = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (state == PUSH) begin
      bus.pc_en      = 1'b0;
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
      bus.int_push   = 1'b1;
    end else if (state == VECTOR) begin
      bus.pc_sel     = 2'b10;
      bus.ifid_flush = 1'b1;
      bus.int_ack    = 1'b1;
    end else if (bus.ex_taken) begin
      bus.pc_sel     = 2'b01;
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (state == DRAIN || struct_hz) begin
      bus.pc_en      = 1'b0;
      bus.ifid_flush = 1'b1;
    end else if (load_use) begin
      bus.pc_en      = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.idex_flush = 1'b1;
    end
    if (!rst && state == IDLE && !bus.ex_taken && load_use) begin
      bus.pc_en      = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.ifid_flush = 1'b0;
      bus.idex_flush = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : nxt;
    ex_s  <= (rst | bus.idex_flush) ? '0 :
             {bus.id_valid, bus.id_wr, bus.id_rd, bus.id_load, bus.id_mem};
    mem_s <= rst ? '0 : ex_s;
  end
endmodule

// File: tb/tb_pipe_sched.sv
// tb_pipe_sched: scenario tasks drive per-cycle stimulus and score hand-derived control vectors
module tb_pipe_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pipe_sched_if bus ();
  pipe_sched dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic       r;
    logic       v;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [1:0] rds;
    logic       wr;
    logic [1:0] rd;
    logic       ld;
    logic       mm;
    logic       tk;
    logic       irq;
  } stim_t;
  // {pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b, int_push, int_ack}
  localparam logic [11:0] RSTV   = 12'b0_00_1_1_1_00_00_0_0 & 12'b0_00_0_1_1_00_00_0_0;
  localparam logic [11:0] NORM   = 12'b1_00_1_0_0_00_00_0_0;
  localparam logic [11:0] LU     = 12'b0_00_0_0_1_00_00_0_0;
  localparam logic [11:0] STR    = 12'b0_00_1_1_0_00_00_0_0;
  localparam logic [11:0] BR     = 12'b1_01_1_1_1_00_00_0_0;
  localparam logic [11:0] DRN    = 12'b0_00_1_1_0_00_00_0_0;
  localparam logic [11:0] PSH    = 12'b0_00_1_1_1_00_00_1_0;
  localparam logic [11:0] VEC    = 12'b1_10_1_1_0_00_00_0_1;
  localparam logic [11:0] FA_EX  = 12'h010;
  localparam logic [11:0] FA_MEM = 12'h020;
  localparam logic [11:0] FB_EX  = 12'h004;
  localparam logic [11:0] FB_MEM = 12'h008;
  logic [11:0] outs;
  logic [11:0] exp_q[$];
  int applied = 0;
  int miscompares = 0;
  assign outs = {bus.pc_en, bus.pc_sel, bus.ifid_en, bus.ifid_flush, bus.idex_flush,
                 bus.fwd_a, bus.fwd_b, bus.int_push, bus.int_ack};
  function automatic stim_t nop();
    return '0;
  endfunction
  function automatic stim_t rstc();
    stim_t s = '0;
    s.r = 1'b1;
    return s;
  endfunction
  function automatic stim_t ins(input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rds,
                                input logic wr, input logic [1:0] rd, input logic ld, input logic mm);
    stim_t s = '0;
    s.v = 1'b1; s.ra = ra; s.rb = rb; s.rds = rds; s.wr = wr; s.rd = rd; s.ld = ld; s.mm = mm;
    return s;
  endfunction
  function automatic stim_t tk(input stim_t s);
    s.tk = 1'b1;
    return s;
  endfunction
  function automatic stim_t irq(input stim_t s);
    s.irq = 1'b1;
    return s;
  endfunction
  task automatic drive(input stim_t s);
    rst = s.r;
    bus.id_valid = s.v; bus.id_ra = s.ra; bus.id_rb = s.rb; bus.id_reads = s.rds;
    bus.id_wr = s.wr; bus.id_rd = s.rd; bus.id_load = s.ld; bus.id_mem = s.mm;
    bus.ex_taken = s.tk; bus.int_req = s.irq;
  endtask
  task automatic test_reset();
    stim_t s[3];
    logic [11:0] x[3];
    logic [11:0] e;
    s = '{rstc(), tk(rstc()), nop()};
    x = '{RSTV, RSTV, NORM};
    for (int i = 0; i < 3; i++) begin
      drive(s[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      e = exp_q.pop_front(); applied++;
      if (outs !== e) begin miscompares++; $display("FAIL reset[%0d]: got %b want %b", i, outs, e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_forward();
    stim_t s[7];
    logic [11:0] x[7];
    logic [11:0] e;
    s = '{rstc(), ins(2'd0, 2'd0, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0),
          ins(2'd1, 2'd0, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0), ins(2'd0, 2'd1, 2'b01, 1'b0, 2'd0, 1'b0, 1'b0),
          ins(2'd0, 2'd0, 2'b00, 1'b1, 2'd3, 1'b0, 1'b0), ins(2'd0, 2'd0, 2'b00, 1'b1, 2'd3, 1'b0, 1'b0),
          ins(2'd3, 2'd3, 2'b11, 1'b0, 2'd0, 1'b0, 1'b0)};
    x = '{RSTV, NORM, NORM | FA_EX, NORM | FB_MEM, NORM, NORM, NORM | FA_EX | FB_EX};
    for (int i = 0; i < 7; i++) begin
      drive(s[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      e = exp_q.pop_front(); applied++;
      if (outs !== e) begin miscompares++; $display("FAIL forward[%0d]: got %b want %b", i, outs, e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_load_use();
    stim_t s[7];
    logic [11:0] x[7];
    logic [11:0] e;
    s = '{rstc(), ins(2'd0, 2'd0, 2'b00, 1'b1, 2'd2, 1'b1, 1'b1),
          ins(2'd2, 2'd0, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0), ins(2'd2, 2'd0, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0),
          nop(), ins(2'd0, 2'd0, 2'b00, 1'b1, 2'd2, 1'b1, 1'b1),
          ins(2'd0, 2'd2, 2'b01, 1'b0, 2'd0, 1'b0, 1'b0)};
    x = '{RSTV, NORM, LU, STR | FA_MEM, NORM, NORM, LU};
    for (int i = 0; i < 7; i++) begin
      drive(s[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      e = exp_q.pop_front(); applied++;
      if (outs !== e) begin miscompares++; $display("FAIL load_use[%0d]: got %b want %b", i, outs, e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_structural();
    stim_t s[5];
    logic [11:0] x[5];
    logic [11:0] e;
    s = '{rstc(), ins(2'd1, 2'd2, 2'b11, 1'b0, 2'd0, 1'b0, 1'b1),
          ins(2'd0, 2'd0, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0), ins(2'd0, 2'd0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0),
          ins(2'd0, 2'd0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0)};
    x = '{RSTV, NORM, NORM, STR, NORM};
    for (int i = 0; i < 5; i++) begin
      drive(s[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      e = exp_q.pop_front(); applied++;
      if (outs !== e) begin miscompares++; $display("FAIL structural[%0d]: got %b want %b", i, outs, e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_branch();
    stim_t s[5];
    logic [11:0] x[5];
    logic [11:0] e;
    s = '{rstc(), ins(2'd0, 2'd0, 2'b00, 1'b1, 2'd0, 1'b1, 1'b1),
          tk(ins(2'd0, 2'd0, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0)), nop(), nop()};
    x = '{RSTV, NORM, BR, STR, NORM};
    for (int i = 0; i < 5; i++) begin
      drive(s[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      e = exp_q.pop_front(); applied++;
      if (outs !== e) begin miscompares++; $display("FAIL branch[%0d]: got %b want %b", i, outs, e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_interrupt();
    stim_t s[10];
    logic [11:0] x[10];
    logic [11:0] e;
    s = '{rstc(), ins(2'd0, 2'd0, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0),
          ins(2'd0, 2'd0, 2'b00, 1'b1, 2'd2, 1'b0, 1'b0), irq(ins(2'd0, 2'd0, 2'b00, 1'b1, 2'd3, 1'b0, 1'b0)),
          nop(), nop(), nop(), nop(), nop(), nop()};
    x = '{RSTV, NORM, NORM, NORM, DRN, DRN, DRN, PSH, VEC, NORM};
    for (int i = 0; i < 10; i++) begin
      drive(s[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      e = exp_q.pop_front(); applied++;
      if (outs !== e) begin miscompares++; $display("FAIL interrupt[%0d]: got %b want %b", i, outs, e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_drain_branch();
    stim_t s[7];
    logic [11:0] x[7];
    logic [11:0] e;
    s = '{rstc(), irq(ins(2'd0, 2'd0, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0)), tk(nop()), nop(), nop(), nop(), nop()};
    x = '{RSTV, NORM, BR, DRN, DRN, PSH, VEC};
    for (int i = 0; i < 7; i++) begin
      drive(s[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      e = exp_q.pop_front(); applied++;
      if (outs !== e) begin miscompares++; $display("FAIL drain_branch[%0d]: got %b want %b", i, outs, e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset_mid();
    stim_t s[8];
    logic [11:0] x[8];
    logic [11:0] e;
    s = '{rstc(), irq(ins(2'd0, 2'd0, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0)), nop(), nop(), nop(), rstc(),
          ins(2'd1, 2'd1, 2'b11, 1'b0, 2'd0, 1'b0, 1'b0), nop()};
    x = '{RSTV, NORM, DRN, DRN, DRN, RSTV, NORM, NORM};
    for (int i = 0; i < 8; i++) begin
      drive(s[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      e = exp_q.pop_front(); applied++;
      if (outs !== e) begin miscompares++; $display("FAIL reset_mid[%0d]: got %b want %b", i, outs, e); end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_structural();
    test_branch();
    test_interrupt();
    test_drain_branch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
